// File: rtl/rf_alu_pkg.sv
// Shared opcode encoding for the register-file ALU pipeline.
package rf_alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'd0;
  localparam opcode_t OP_SUB = 3'd1;
  localparam opcode_t OP_AND = 3'd2;
  localparam opcode_t OP_OR  = 3'd3;
  localparam opcode_t OP_XOR = 3'd4;
  localparam opcode_t OP_SHL = 3'd5;
  localparam opcode_t OP_SHR = 3'd6;
  localparam opcode_t OP_INC = 3'd7;

endpackage

// File: rtl/rf_alu_core.sv
// Purely combinational ALU: operands are zero-extended by one bit so the
// top bit carries the ADD carry, SUB borrow or SHL overflow.
module rf_alu_core
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_t           op,
  output logic [DATA_W:0]   y
);

  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);

  logic [DATA_W:0] ax;
  logic [DATA_W:0] bx;

  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = ax + bx;
      OP_SUB:  y = ax - bx;
      OP_AND:  y = ax & bx;
      OP_OR:   y = ax | bx;
      OP_XOR:  y = ax ^ bx;
      OP_SHL:  y = {a, 1'b0};
      OP_SHR:  y = ax >> 1;
      OP_INC:  y = ax + ONE;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_alu_pipe.sv
// Register file plus two-stage valid/ready ALU pipeline with optional
// write-back of results into the register file and operand forwarding.
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addrop1,
  input  logic [ADDR_W-1:0] addrop2,
  input  opcode_t           opcode,
  input  logic              sel,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out,
  output logic              zero,
  output logic              wb_drop
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  opcode_t           s1_op;
  logic              s1_sel;
  logic              s1_wb_en;
  logic [ADDR_W-1:0] s1_wb_addr;

  logic [DATA_W:0]   alu_y;
  logic [DATA_W:0]   mux_y;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              s2_load;
  logic              accept;
  logic              wb_fire;
  logic              wb_collide;

  assign s2_load    = s1_valid && (!out_valid || out_ready);
  assign in_ready   = !s1_valid || s2_load;
  assign accept     = in_valid && in_ready;
  assign wb_fire    = s2_load && s1_wb_en;
  assign wb_collide = wb_fire && we && (addr == s1_wb_addr);
  assign mux_y      = s1_sel ? alu_y : {1'b0, s1_a};

  rf_alu_core #(.DATA_W(DATA_W)) u_core (
    .a  (s1_a),
    .b  (s1_b),
    .op (s1_op),
    .y  (alu_y)
  );

  // Forwarding priority: same-edge external write, then the S1 write-back, then RAM.
  always_comb begin
    opa = '0;
    if (in_range(addrop1)) begin
      if (we && addr == addrop1)                opa = data;
      else if (wb_fire && s1_wb_addr == addrop1) opa = alu_y[DATA_W-1:0];
      else                                      opa = mem[addrop1];
    end
  end

  always_comb begin
    opb = '0;
    if (in_range(addrop2)) begin
      if (we && addr == addrop2)                opb = data;
      else if (wb_fire && s1_wb_addr == addrop2) opb = alu_y[DATA_W-1:0];
      else                                      opb = mem[addrop2];
    end
  end

  // A colliding external write takes the word; the write-back is simply not performed.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we && in_range(addr))
        mem[addr] <= data;
      if (wb_fire && !wb_collide && in_range(s1_wb_addr))
        mem[s1_wb_addr] <= alu_y[DATA_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_sel     <= 1'b0;
      s1_wb_en   <= 1'b0;
      s1_wb_addr <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_a       <= opa;
      s1_b       <= opb;
      s1_op      <= opcode;
      s1_sel     <= sel;
      s1_wb_en   <= wb_en;
      s1_wb_addr <= wb_addr;
    end else if (s2_load) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      wb_drop   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out       <= mux_y;
        zero      <= (mux_y[DATA_W-1:0] == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wb_collide)
        wb_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_alu_pipe.sv
// Directed testbench for rf_alu_pipe with hand-computed expected values.
module tb_rf_alu_pipe;
  import rf_alu_pkg::*;

  logic       clock;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [3:0] data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] addrop1;
  logic [3:0] addrop2;
  opcode_t    opcode;
  logic       sel;
  logic       wb_en;
  logic [3:0] wb_addr;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out;
  logic       zero;
  logic       wb_drop;

  int n_cmp = 0;
  int n_bad = 0;

  rf_alu_pipe dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addrop1   (addrop1),
    .addrop2   (addrop2),
    .opcode    (opcode),
    .sel       (sel),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .wb_drop   (wb_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    we = 0; addr = 0; data = 0; in_valid = 0; addrop1 = 0; addrop2 = 0;
    opcode = OP_ADD; sel = 1; wb_en = 0; wb_addr = 0; out_ready = 1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [3:0] d);
    @(negedge clock);
    we = 1; addr = a; data = d;
    @(negedge clock);
    we = 0;
  endtask

  // Issues one op with out_ready=1; res stays X if accept or result never arrives.
  task automatic run_op(input logic [3:0] a1, input logic [3:0] a2, input opcode_t op,
                        input logic s, input logic wbe, input logic [3:0] wba,
                        output logic [4:0] res, output logic z, output int lat);
    int tries;
    res = 'x; z = 'x; lat = -1; tries = 0;
    @(negedge clock);
    in_valid = 1; addrop1 = a1; addrop2 = a2; opcode = op; sel = s;
    wb_en = wbe; wb_addr = wba; out_ready = 1;
    #1;
    while (!in_ready && tries < 20) begin
      @(negedge clock); #1; tries++;
    end
    if (!in_ready) begin
      in_valid = 0;
      return;
    end
    @(negedge clock);
    in_valid = 0; wb_en = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1 || !out_valid) @(negedge clock);
      if (out_valid) begin
        res = out; z = zero; lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out !== 5'h00) begin n_bad++; $display("[TB] FAIL reset_out: got %h want 00", out); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_zero: got %b want 0", zero); end
    n_cmp++; if (wb_drop !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wb_drop: got %b want 0", wb_drop); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clock);
    rst_n = 1;
  endtask

  task automatic test_add();
    logic [4:0] res; logic z; int lat;
    write_mem(4'd2, 4'd9);
    write_mem(4'd3, 4'd8);
    run_op(4'd2, 4'd3, OP_ADD, 1'b1, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'h11) begin n_bad++; $display("[TB] FAIL add_out: got %h want 11", res); end
    n_cmp++; if (z !== 1'b0) begin n_bad++; $display("[TB] FAIL add_zero: got %b want 0", z); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("[TB] FAIL add_latency: got %0d want 1", lat); end
  endtask

  task automatic test_opcodes();
    logic [4:0] res; logic z; int lat;
    logic [4:0] exp_35 [8] = '{5'd8, 5'd30, 5'd1, 5'd7, 5'd6, 5'd6, 5'd1, 5'd4};
    logic [4:0] exp_98 [8] = '{5'd17, 5'd1, 5'd8, 5'd9, 5'd1, 5'd18, 5'd4, 5'd10};
    write_mem(4'd5, 4'd3);
    write_mem(4'd6, 4'd5);
    for (int i = 0; i < 8; i++) begin
      run_op(4'd5, 4'd6, opcode_t'(i), 1'b1, 1'b0, 4'd0, res, z, lat);
      n_cmp++; if (res !== exp_35[i]) begin n_bad++; $display("[TB] FAIL op%0d_a3_b5: got %h want %h", i, res, exp_35[i]); end
      run_op(4'd2, 4'd3, opcode_t'(i), 1'b1, 1'b0, 4'd0, res, z, lat);
      n_cmp++; if (res !== exp_98[i]) begin n_bad++; $display("[TB] FAIL op%0d_a9_b8: got %h want %h", i, res, exp_98[i]); end
    end
    run_op(4'd5, 4'd6, OP_SUB, 1'b0, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'h03) begin n_bad++; $display("[TB] FAIL sub_raw: got %h want 03", res); end
    run_op(4'd3, 4'd3, OP_ADD, 1'b1, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if ({res, z} !== {5'h10, 1'b1}) begin n_bad++; $display("[TB] FAIL add_carry_zero: got %h/%b want 10/1", res, z); end
    run_op(4'd2, 4'd2, OP_XOR, 1'b1, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if ({res, z} !== {5'h00, 1'b1}) begin n_bad++; $display("[TB] FAIL xor_zero: got %h/%b want 00/1", res, z); end
  endtask

  task automatic test_forward();
    logic [4:0] res; logic z; int lat;
    logic v1, v2; logic [4:0] o1, o2;
    write_mem(4'd1, 4'd6);
    @(negedge clock);
    out_ready = 1; in_valid = 1; addrop1 = 1; addrop2 = 1; opcode = OP_ADD;
    sel = 1; wb_en = 1; wb_addr = 4;
    @(negedge clock);
    addrop1 = 4; addrop2 = 4; wb_en = 0;
    @(negedge clock);
    in_valid = 0;
    v1 = out_valid; o1 = out;
    @(negedge clock);
    v2 = out_valid; o2 = out;
    n_cmp++; if ({v1, o1} !== {1'b1, 5'd12}) begin n_bad++; $display("[TB] FAIL fwd_op1: got %b/%0d want 1/12", v1, o1); end
    n_cmp++; if ({v2, o2} !== {1'b1, 5'd24}) begin n_bad++; $display("[TB] FAIL fwd_op2: got %b/%0d want 1/24", v2, o2); end
    run_op(4'd4, 4'd0, OP_ADD, 1'b0, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'd12) begin n_bad++; $display("[TB] FAIL fwd_mem4: got %0d want 12", res); end
    // External write forwarded on the same edge as operand capture.
    @(negedge clock);
    we = 1; addr = 8; data = 5;
    in_valid = 1; addrop1 = 8; addrop2 = 8; opcode = OP_ADD; sel = 1;
    @(negedge clock);
    we = 0; in_valid = 0;
    @(negedge clock);
    n_cmp++; if ({out_valid, out} !== {1'b1, 5'd10}) begin n_bad++; $display("[TB] FAIL fwd_ext: got %b/%0d want 1/10", out_valid, out); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op_addr [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
    logic [4:0] exp_res [4] = '{5'd7, 5'd10, 5'd9, 5'd4};
    logic [4:0] got [4];
    int issued, received;
    logic ir;
    issued = 0; received = 0;
    for (int c = 0; c < 40 && received < 4; c++) begin
      @(negedge clock);
      out_ready = (c >= 5);
      if (issued < 4) begin
        in_valid = 1; addrop1 = op_addr[issued]; addrop2 = 0; opcode = OP_INC; sel = 1; wb_en = 0;
      end else begin
        in_valid = 0;
      end
      #1;
      ir = in_ready;
      if (out_valid) begin
        if (!out_ready) begin
          n_cmp++; if (out !== exp_res[0]) begin n_bad++; $display("[TB] FAIL bp_hold_c%0d: got %0d want %0d", c, out, exp_res[0]); end
        end else begin
          got[received] = out;
          received++;
        end
      end
      if (c == 4) begin
        n_cmp++; if ({issued, ir} !== {32'd2, 1'b0}) begin n_bad++; $display("[TB] FAIL bp_stall: got %0d accepts/in_ready %b want 2/0", issued, ir); end
      end
      @(posedge clock);
      if (in_valid && ir) issued++;
    end
    @(negedge clock);
    in_valid = 0; out_ready = 1;
    n_cmp++; if (received !== 4) begin n_bad++; $display("[TB] FAIL bp_count: got %0d want 4", received); end
    for (int i = 0; i < received && i < 4; i++) begin
      n_cmp++; if (got[i] !== exp_res[i]) begin n_bad++; $display("[TB] FAIL bp_order%0d: got %0d want %0d", i, got[i], exp_res[i]); end
    end
  endtask

  task automatic test_collision();
    logic [4:0] res; logic z; int lat;
    n_cmp++; if (wb_drop !== 1'b0) begin n_bad++; $display("[TB] FAIL coll_pre_drop: got %b want 0", wb_drop); end
    @(negedge clock);
    out_ready = 1; in_valid = 1; addrop1 = 2; addrop2 = 0; opcode = OP_INC; sel = 1; wb_en = 1; wb_addr = 7;
    @(negedge clock);
    in_valid = 0; wb_en = 0;
    we = 1; addr = 7; data = 3;
    @(negedge clock);
    we = 0;
    n_cmp++; if ({out_valid, out} !== {1'b1, 5'd10}) begin n_bad++; $display("[TB] FAIL coll_out: got %b/%0d want 1/10", out_valid, out); end
    n_cmp++; if (wb_drop !== 1'b1) begin n_bad++; $display("[TB] FAIL coll_drop: got %b want 1", wb_drop); end
    run_op(4'd7, 4'd0, OP_ADD, 1'b0, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'd3) begin n_bad++; $display("[TB] FAIL coll_mem7: got %0d want 3", res); end
    n_cmp++; if (wb_drop !== 1'b1) begin n_bad++; $display("[TB] FAIL coll_sticky: got %b want 1", wb_drop); end
  endtask

  task automatic test_reset_midflight();
    logic [4:0] res; logic z; int lat;
    @(negedge clock);
    out_ready = 0; in_valid = 1; addrop1 = 2; addrop2 = 0; opcode = OP_INC; sel = 1; wb_en = 1; wb_addr = 9;
    @(negedge clock);
    addrop1 = 3;
    @(negedge clock);
    in_valid = 0; wb_en = 0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_bad++; $display("[TB] FAIL mid_inflight: got %b%b want 10", out_valid, in_ready); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({out_valid, out} !== {1'b0, 5'd0}) begin n_bad++; $display("[TB] FAIL mid_reset_out: got %b/%0d want 0/0", out_valid, out); end
    n_cmp++; if ({in_ready, wb_drop} !== 2'b10) begin n_bad++; $display("[TB] FAIL mid_reset_flags: got %b%b want 10", in_ready, wb_drop); end
    @(negedge clock);
    rst_n = 1; out_ready = 1;
    repeat (3) begin
      @(negedge clock);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_no_output: got %b want 0", out_valid); end
    end
    run_op(4'd9, 4'd0, OP_ADD, 1'b0, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'd0) begin n_bad++; $display("[TB] FAIL mid_mem9: got %0d want 0", res); end
    run_op(4'd2, 4'd0, OP_ADD, 1'b0, 1'b0, 4'd0, res, z, lat);
    n_cmp++; if (res !== 5'd0) begin n_bad++; $display("[TB] FAIL mid_mem2: got %0d want 0", res); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_opcodes();
    test_forward();
    test_back_to_back();
    test_collision();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
